// File: rtl/bsg_manycore_link_sdr_tx_mux.sv
// Credit-managed N-channel SDR transmit mux: round-robin over channels
// with credit, registered word + channel tag out to the SDR launch stage.
// Ports: core_v_i/core_data_i/core_yumi_o per-channel input streams,
//   token_i per-channel credit returns, link_v_o/link_data_o/link_ch_o
//   registered uplink word, credits_o debug counts, err_o overflow flag.
// Optional: BSG_MANYCORE_LINK_SDR_TX_MUX_CREDIT_CHECK_EN enables the
//   sticky credit-overflow flag on err_o (tied low otherwise).
module bsg_manycore_link_sdr_tx_mux #(
    parameter int num_channels_p = 2,
    parameter int width_p = 16,
    parameter int lg_fifo_depth_p = 3,
    parameter int lg_credit_to_token_decimation_p = 0,
    parameter int init_wait_cycles_p = 16,
    parameter int lg_ch_lp =
        (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
    input  logic core_clk_i,
    input  logic core_reset_n_i,
    input  logic [num_channels_p-1:0] core_v_i,
    input  logic [num_channels_p*width_p-1:0] core_data_i,
    output logic [num_channels_p-1:0] core_yumi_o,
    input  logic [num_channels_p-1:0] token_i,
    output logic link_v_o,
    output logic [width_p-1:0] link_data_o,
    output logic [lg_ch_lp-1:0] link_ch_o,
    output logic [num_channels_p*(lg_fifo_depth_p+1)-1:0] credits_o,
    output logic err_o
);

    localparam int cw_lp = lg_fifo_depth_p + 1;
    localparam logic [cw_lp-1:0] full_lp = cw_lp'(2 ** lg_fifo_depth_p);
    localparam logic [cw_lp:0] full_x_lp = (cw_lp + 1)'(2 ** lg_fifo_depth_p);
    localparam logic [cw_lp:0] tok_lp =
        (cw_lp + 1)'(2 ** lg_credit_to_token_decimation_p);
    localparam int term_lp =
        (init_wait_cycles_p > 0) ? init_wait_cycles_p - 1 : 0;
    localparam int wcw_lp =
        (init_wait_cycles_p > 1) ? $clog2(init_wait_cycles_p) : 1;
    localparam logic [wcw_lp-1:0] term_cnt_lp = wcw_lp'(term_lp);

    typedef enum logic {
        e_wait,
        e_active
    } state_e;

    state_e state_r;
    logic [wcw_lp-1:0] wait_cnt_r;
    logic wait_done_r;

    // Terminal count is registered first, so ACTIVE begins one cycle
    // after the counter reaches init_wait_cycles_p-1.
    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            state_r <= e_wait;
            wait_cnt_r <= '0;
            wait_done_r <= 1'b0;
        end else begin
            unique case (state_r)
                e_wait: begin
                    if (wait_done_r) begin
                        state_r <= e_active;
                    end else if (wait_cnt_r == term_cnt_lp) begin
                        wait_done_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                e_active: state_r <= e_active;
                default: state_r <= e_wait;
            endcase
        end
    end

    logic [cw_lp-1:0] credit_r [num_channels_p];
    logic [cw_lp-1:0] credit_n [num_channels_p];
    logic [cw_lp:0] credit_sum [num_channels_p];
    logic [num_channels_p-1:0] ovf;
    logic [num_channels_p-1:0] elig;
    logic [num_channels_p-1:0] gnt;
    logic [lg_ch_lp-1:0] rr_ptr_r;
    logic [lg_ch_lp-1:0] gnt_idx;
    logic [width_p-1:0] gnt_data;
    logic gnt_v;
    int idx;

    // Round-robin search starting at rr_ptr_r, wrapping to channel 0.
    always_comb begin
        elig = '0;
        gnt_v = 1'b0;
        gnt_idx = '0;
        gnt_data = '0;
        idx = 0;
        for (int c = 0; c < num_channels_p; c++) begin
            elig[c] = core_v_i[c] & (credit_r[c] != '0);
        end
        for (int i = 0; i < num_channels_p; i++) begin
            idx = int'(rr_ptr_r) + i;
            if (idx >= num_channels_p) begin
                idx = idx - num_channels_p;
            end
            if (!gnt_v && elig[idx]) begin
                gnt_v = 1'b1;
                gnt_idx = lg_ch_lp'(idx);
                gnt_data = core_data_i[idx*width_p +: width_p];
            end
        end
        if (state_r != e_active) begin
            gnt_v = 1'b0;
        end
        gnt = gnt_v ? (num_channels_p'(1) << gnt_idx) : '0;
    end

    assign core_yumi_o = gnt;

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            rr_ptr_r <= '0;
        end else if (gnt_v) begin
            if (int'(gnt_idx) == num_channels_p - 1) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= gnt_idx + 1'b1;
            end
        end
    end

    // One extra bit so grant and token can both apply before the
    // saturation compare. A grant never lands on a zero counter.
    always_comb begin
        ovf = '0;
        for (int c = 0; c < num_channels_p; c++) begin
            credit_sum[c] = {1'b0, credit_r[c]}
                - (cw_lp + 1)'(gnt[c])
                + (token_i[c] ? tok_lp : '0);
            credit_n[c] = credit_sum[c][cw_lp-1:0];
            if (state_r != e_active) begin
                credit_n[c] = full_lp;
            end else if (credit_sum[c] > full_x_lp) begin
                ovf[c] = 1'b1;
                credit_n[c] = full_lp;
            end
        end
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            for (int c = 0; c < num_channels_p; c++) begin
                credit_r[c] <= full_lp;
            end
        end else begin
            for (int c = 0; c < num_channels_p; c++) begin
                credit_r[c] <= credit_n[c];
            end
        end
    end

    always_comb begin
        credits_o = '0;
        for (int c = 0; c < num_channels_p; c++) begin
            credits_o[c*cw_lp +: cw_lp] = credit_r[c];
        end
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            link_v_o <= 1'b0;
            link_data_o <= '0;
            link_ch_o <= '0;
        end else begin
            link_v_o <= gnt_v;
            if (gnt_v) begin
                link_data_o <= gnt_data;
                link_ch_o <= gnt_idx;
            end
        end
    end

`ifdef BSG_MANYCORE_LINK_SDR_TX_MUX_CREDIT_CHECK_EN
    logic err_r;

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            err_r <= 1'b0;
        end else if (|ovf) begin
            err_r <= 1'b1;
        end
    end

    always @(posedge core_clk_i) begin
        for (int c = 0; c < num_channels_p; c++) begin
            if (core_reset_n_i && ovf[c]) begin
                $error("credit overflow on channel %0d", c);
            end
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_manycore_link_sdr_tx_mux.sv
// Directed bench for bsg_manycore_link_sdr_tx_mux: a 3-channel instance
// (decimation 0) and a 2-channel instance (decimation 2).
module tb_bsg_manycore_link_sdr_tx_mux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0] va, ta, yumi_a;
    logic [23:0] data_a = {8'hA2, 8'hA1, 8'hA0};
    logic link_v_a, err_a;
    logic [7:0] link_data_a;
    logic [1:0] link_ch_a;
    logic [11:0] credits_a;

    logic [1:0] vb, tb, yumi_b;
    logic [15:0] data_b = {8'h66, 8'h5A};
    logic link_v_b, err_b;
    logic [7:0] link_data_b;
    logic [0:0] link_ch_b;
    logic [7:0] credits_b;

    bsg_manycore_link_sdr_tx_mux #(
        .num_channels_p(3),
        .width_p(8),
        .lg_fifo_depth_p(3),
        .lg_credit_to_token_decimation_p(0),
        .init_wait_cycles_p(16)
    ) dut_a (
        .core_clk_i(clk),
        .core_reset_n_i(rst_n),
        .core_v_i(va),
        .core_data_i(data_a),
        .core_yumi_o(yumi_a),
        .token_i(ta),
        .link_v_o(link_v_a),
        .link_data_o(link_data_a),
        .link_ch_o(link_ch_a),
        .credits_o(credits_a),
        .err_o(err_a)
    );

    bsg_manycore_link_sdr_tx_mux #(
        .num_channels_p(2),
        .width_p(8),
        .lg_fifo_depth_p(3),
        .lg_credit_to_token_decimation_p(2),
        .init_wait_cycles_p(16)
    ) dut_b (
        .core_clk_i(clk),
        .core_reset_n_i(rst_n),
        .core_v_i(vb),
        .core_data_i(data_b),
        .core_yumi_o(yumi_b),
        .token_i(tb),
        .link_v_o(link_v_b),
        .link_data_o(link_data_b),
        .link_ch_o(link_ch_b),
        .credits_o(credits_b),
        .err_o(err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic cyc(input logic [2:0] v_a, input logic [2:0] t_a,
                       input logic [1:0] v_b, input logic [1:0] t_b);
        @(negedge clk);
        va = v_a;
        ta = t_a;
        vb = v_b;
        tb = t_b;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    int g1 [6] = '{0, 1, 2, 0, 1, 2};
    int g2 [4] = '{0, 2, 0, 2};
    int prev, n, first, last;
    logic saw;
    logic err_exp;

    initial begin
        rst_n = 1'b0;
        va = '0; ta = '0; vb = '0; tb = '0;
`ifdef BSG_MANYCORE_LINK_SDR_TX_MUX_CREDIT_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif

        @(negedge clk);
        va = 3'b111;
        #1;
        check("rst_link_v", 32'(link_v_a), 0);
        check("rst_link_data", 32'(link_data_a), 0);
        check("rst_link_ch", 32'(link_ch_a), 0);
        check("rst_yumi", 32'(yumi_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_credits_a", 32'(credits_a), 32'h888);
        check("rst_credits_b", 32'(credits_b), 32'h88);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("wait_c0_yumi", 32'(yumi_a), 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(3'b111, 0, 0, 0);
            check("wait_yumi", 32'(yumi_a), 0);
        end
        check("wait_link_v", 32'(link_v_a), 0);
        check("wait_credits", 32'(credits_a), 32'h888);

        for (int i = 0; i < 6; i++) begin
            cyc(3'b111, 0, 0, 0);
            check("rr_yumi", 32'(yumi_a), 32'(1 << g1[i]));
            if (i > 0) begin
                check("rr_link_ch", 32'(link_ch_a), 32'(g1[i-1]));
                check("rr_link_data", 32'(link_data_a),
                      32'(8'hA0 + g1[i-1]));
            end
        end

        prev = 2;
        for (int i = 0; i < 4; i++) begin
            cyc(3'b101, 0, 0, 0);
            check("rr2_yumi", 32'(yumi_a), 32'(1 << g2[i]));
            check("rr2_link_ch", 32'(link_ch_a), 32'(prev));
            check("rr2_link_v", 32'(link_v_a), 1);
            prev = g2[i];
        end

        cyc(3'b111, 0, 0, 0);
        check("rr_tail_link_v", 32'(link_v_a), 1);
        check("rr_tail_link_ch", 32'(link_ch_a), 2);
        check("rr_tail_link_data", 32'(link_data_a), 32'hA2);
        check("rr_credits", 32'(credits_a), 32'h464);

        #2;
        rst_n = 1'b0;
        #1;
        check("arst_link_v", 32'(link_v_a), 0);
        check("arst_credits", 32'(credits_a), 32'h888);
        check("arst_yumi", 32'(yumi_a), 0);

        @(negedge clk);
        rst_n = 1'b1;
        va = 3'b001;
        #1;
        check("rel_c0_yumi", 32'(yumi_a), 0);
        check("rel_credits", 32'(credits_a), 32'h888);
        saw = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(3'b001, 0, 0, 0);
            saw = saw | yumi_a[0];
        end
        check("rel_wait_no_yumi", 32'(saw), 0);

        n = 0; first = -1; last = -1;
        for (int k = 0; k < 12; k++) begin
            cyc(3'b001, 0, 0, 0);
            if (yumi_a[0]) begin
                n++;
                if (first < 0) first = k;
                last = k;
            end
        end
        check("exh_count", 32'(n), 8);
        check("exh_first", 32'(first), 0);
        check("exh_last", 32'(last), 7);
        check("exh_yumi", 32'(yumi_a), 0);
        check("exh_credit0", 32'(credits_a[3:0]), 0);

        cyc(3'b001, 3'b001, 0, 0);
        check("tok_c0_yumi", 32'(yumi_a), 0);
        cyc(3'b001, 3'b001, 0, 0);
        check("tok_credit1", 32'(credits_a[3:0]), 1);
        check("tok_yumi", 32'(yumi_a), 1);
        cyc(0, 0, 0, 0);
        check("simul_credit", 32'(credits_a[3:0]), 1);
        for (int k = 0; k < 7; k++) begin
            cyc(0, 3'b001, 0, 0);
        end
        cyc(0, 0, 0, 0);
        check("refill_credit", 32'(credits_a[3:0]), 8);
        check("refill_err", 32'(err_a), 0);
        cyc(0, 3'b001, 0, 0);
        cyc(0, 0, 0, 0);
        check("sat_credit", 32'(credits_a[3:0]), 8);
        check("sat_err", 32'(err_a), 32'(err_exp));

        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 2'b01, 0);
            if (yumi_b[0]) n++;
        end
        check("b_exh_count", 32'(n), 8);
        check("b_exh_credit", 32'(credits_b[3:0]), 0);
        check("b_link_data", 32'(link_data_b), 32'h5A);

        cyc(0, 0, 2'b01, 2'b01);
        check("b_tok_yumi", 32'(yumi_b), 0);
        n = 0; first = -1; last = -1;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 2'b01, 0);
            if (k == 0) begin
                check("b_dec_credit", 32'(credits_b[3:0]), 4);
            end
            if (yumi_b[0]) begin
                n++;
                if (first < 0) first = k;
                last = k;
            end
        end
        check("b_dec_count", 32'(n), 4);
        check("b_dec_first", 32'(first), 0);
        check("b_dec_last", 32'(last), 3);
        check("b_dec_credit_end", 32'(credits_b[3:0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_link_sdr_tx_mux.md
# bsg_manycore_link_sdr_tx_mux

Credit-managed, multi-channel SDR transmit mux. It arbitrates `num_channels_p` manycore packet streams onto one shared SDR uplink and tags each word with its channel id. Each channel keeps its own credit counter, replenished by decimated token pulses from the receiver. The block generalises the fixed fwd/rev pair of the manycore SDR link endpoint to N channels sharing one set of pins, and it sits between the I/O router's proc link and the pad-side SDR launch flops.

## Interface
Parameters:
- `num_channels_p`, 2: number of independent channels (2..8).
- `width_p`, "inv": payload width in bits, set to the widest packet (fwd packet width).
- `lg_fifo_depth_p`, 3: log2 of the receiver FIFO depth per channel. Initial credits = 2^lg_fifo_depth_p.
- `lg_credit_to_token_decimation_p`, 0: each token pulse returns 2^lg_credit_to_token_decimation_p credits. Must be <= lg_fifo_depth_p.
- `init_wait_cycles_p`, 16: cycles held in WAIT after reset release before any send.
- `lg_ch_lp`, `` `BSG_SAFE_CLOG2(num_channels_p) ``: width of the channel tag.

Ports:
- `core_clk_i` in 1: the only clock.
- `core_reset_n_i` in 1: reset, asynchronous, active-low. Assertion takes effect immediately; deassertion is synchronous to `core_clk_i`.
- `core_v_i` in num_channels_p: per-channel valid.
- `core_data_i` in num_channels_p*width_p: per-channel payload, channel c in bits [c*width_p +: width_p].
- `core_yumi_o` out num_channels_p: one-hot or zero; the word on channel c is consumed this cycle.
- `token_i` in num_channels_p: per-channel token pulse. Already synchronised to `core_clk_i`; one pulse per cycle max.
- `link_v_o` out 1: registered valid to the SDR launch stage.
- `link_data_o` out width_p: registered payload.
- `link_ch_o` out lg_ch_lp: registered channel tag.
- `credits_o` out num_channels_p*(lg_fifo_depth_p+1): per-channel credit counts, for debug.
- `err_o` out 1: sticky credit-overflow error (see Configuration).

## Operation
- FSM states:
  - WAIT: entered on reset; counter counts 0..init_wait_cycles_p-1. `core_yumi_o` = 0; token pulses are ignored. Moves to ACTIVE on the cycle after the counter hits its terminal count.
  - ACTIVE: normal operation; never leaves except on reset.
- Credits:
  - Width lg_fifo_depth_p+1. Reset value and value throughout WAIT = 2^lg_fifo_depth_p.
  - A channel is eligible when `core_v_i[c]` is high and `credit[c]` != 0.
- Arbitration: round-robin over eligible channels.
  - Search starts at `rr_ptr`, wraps at num_channels_p-1 → 0.
  - The granted channel gets `core_yumi_o[c]`=1, and `rr_ptr` <= c+1 (mod num_channels_p).
  - With no eligible channel, `rr_ptr` holds. Reset value of `rr_ptr` = 0.
- Credit update per channel per cycle: credit_next = credit − yumi[c] + (token_i[c] ? 2^dec : 0).
  - A simultaneous grant and token applies both in the same cycle.
  - If credit_next > 2^lg_fifo_depth_p, the counter saturates at 2^lg_fifo_depth_p and the overflow condition fires.
- Output register: on yumi, `link_data_o`/`link_ch_o` <= the granted channel's data/index and `link_v_o` <= 1. Otherwise `link_v_o` <= 0 and data/tag hold.
- Reset values: `link_v_o`=0, `link_data_o`=0, `link_ch_o`=0, `core_yumi_o`=0 (WAIT), `err_o`=0, state=WAIT.
- Reset asserted mid-transfer: the in-flight registered word is dropped (`link_v_o`→0 asynchronously) and all credits return to full. The receiver must be reset in the same window.

## Timing
- `core_yumi_o` is combinational from `core_v_i`, credits, `rr_ptr` and state. It has no dependency on `token_i` in the same cycle.
- Latency from yumi (cycle t) to `link_v_o` (cycle t+1): 1 cycle.
- A token at cycle t is visible in `credit` at t+1 and can enable a grant at t+1.
- Throughput is 1 word/cycle aggregate. A single channel sustains 1 word/cycle only while it has credit.
- The first possible yumi is at cycle init_wait_cycles_p+1 after reset release.

## Configuration
- `BSG_MANYCORE_LINK_SDR_TX_MUX_CREDIT_CHECK_EN`:
  - Defined: an overflow on any channel sets `err_o`=1 on the next edge; it stays set until reset. Simulation also emits `$error` naming the channel.
  - Undefined: `err_o` is tied to 0, the checker logic is not generated, and saturation still applies.

## Test plan
- Reset and WAIT: init_wait_cycles_p=16, all `core_v_i`=1 → `core_yumi_o`=0 for cycles 0..16 after release, first yumi at cycle 17; `link_v_o`=0 and credits all =8 during WAIT.
- Credit exhaustion: lg_fifo_depth_p=3, channel 0 only, no tokens → exactly 8 yumis, then `core_yumi_o[0]`=0 indefinitely; `credits_o[0]`=0.
- Decimated replenish: decimation=2 with channel 0 at 0 credits; one `token_i[0]` pulse → credits 4 the next cycle, then 4 further words sent on consecutive cycles.
- Round-robin fairness: 3 channels, all valid, ample credit → `link_ch_o` sequence 0,1,2,0,1,2. With channel 1 then dropped, the sequence is 0,2,0,2.
- Simultaneous grant and token: credit 1, yumi and token (dec=0) in the same cycle → credit stays 1; at credit 8 with a token and no grant → credit stays 8 and `err_o`=1 next cycle (macro defined), `err_o`=0 (macro undefined).
- Async reset mid-stream: assert `core_reset_n_i` low between edges while `link_v_o`=1 → `link_v_o`=0 before the next edge; after release, credits =8 and state WAIT.
